// File: rtl/rgb_pwm_fader.sv
// Three-channel 8-bit LED PWM with a jump / linear-fade command interface; duty changes land on PWM period boundaries.
// Optional build macro RGB_PWM_GAMMA_EN: effective duty = (cur*cur)>>8, registered (one extra cycle of latency).
module rgb_pwm_fader #(
   parameter int CLK_DIV  = 4,
   parameter int FADE_DIV = 2
) (
   input  logic        int_osc,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [23:0] cmd_rgb,
   input  logic        cmd_fade,
   output logic        pwm_red,
   output logic        pwm_green,
   output logic        pwm_blue,
   output logic        busy
);

   localparam int DIV_W  = (CLK_DIV > 1)  ? $clog2(CLK_DIV)  : 1;
   localparam int FADE_W = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
   localparam logic [FADE_W-1:0] FADE_LAST = FADE_W'(FADE_DIV - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] JUMP = 2'd1;
   localparam logic [1:0] FADE = 2'd2;

   // Channel index 2 = red, 1 = green, 0 = blue, matching the cmd_rgb byte layout.
   logic [1:0]        state;
   logic [DIV_W-1:0]  div_cnt;
   logic [7:0]        pwm_cnt;
   logic [FADE_W-1:0] fade_cnt;
   logic [2:0][7:0]   cur;
   logic [2:0][7:0]   tgt;
   logic [2:0][7:0]   step_cur;
   logic [2:0][7:0]   duty_eff;
   logic              tick;
   logic              boundary;
   logic              transfer;

   assign tick      = (div_cnt == DIV_LAST);
   assign boundary  = tick && (pwm_cnt == 8'hFF);
   assign cmd_ready = (state == IDLE) && !rst;
   assign transfer  = cmd_valid && cmd_ready;
   assign busy      = (state != IDLE);

   // One saturating fade step: each channel moves 1 toward its target, never past it.
   always_comb begin
      // NOTE: default assignment first, so no path leaves step_cur unassigned and no latch is inferred.
      step_cur = cur;
      for (int i = 0; i < 3; i++) begin
         if (cur[i] < tgt[i]) begin
            step_cur[i] = cur[i] + 8'd1;
         end else if (cur[i] > tgt[i]) begin
            step_cur[i] = cur[i] - 8'd1;
         end
      end
   end

   always_ff @(posedge int_osc) begin
      if (rst) begin
         div_cnt  <= '0;
         pwm_cnt  <= '0;
         fade_cnt <= '0;
         state    <= IDLE;
         cur      <= '0;
         tgt      <= '0;
      end else begin
         // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
         div_cnt <= tick ? '0 : div_cnt + 1'b1;
         if (tick) begin
            pwm_cnt <= pwm_cnt + 8'd1;
         end
         case (state)
            IDLE: begin
               if (transfer) begin
                  tgt      <= cmd_rgb;
                  fade_cnt <= '0;
                  state    <= cmd_fade ? FADE : JUMP;
               end
            end
            JUMP: begin
               if (boundary) begin
                  cur   <= tgt;
                  state <= IDLE;
               end
            end
            FADE: begin
               if (boundary) begin
                  if (fade_cnt == FADE_LAST) begin
                     fade_cnt <= '0;
                     cur      <= step_cur;
                     if (step_cur == tgt) begin
                        state <= IDLE;
                     end
                  end else begin
                     fade_cnt <= fade_cnt + 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef RGB_PWM_GAMMA_EN
   // Squared duty, upper byte of the 16-bit product; the register keeps the multiplier off the compare path.
   always_ff @(posedge int_osc) begin
      if (rst) begin
         duty_eff <= '0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            duty_eff[i] <= 8'((16'(cur[i]) * 16'(cur[i])) >> 8);
         end
      end
   end
`else
   always_comb duty_eff = cur;
`endif

   always_ff @(posedge int_osc) begin
      if (rst) begin
         pwm_red   <= 1'b0;
         pwm_green <= 1'b0;
         pwm_blue  <= 1'b0;
      end else begin
         pwm_red   <= (pwm_cnt < duty_eff[2]);
         pwm_green <= (pwm_cnt < duty_eff[1]);
         pwm_blue  <= (pwm_cnt < duty_eff[0]);
      end
   end

endmodule
